// File: rtl/mux4_arb_pkg.sv
// Shared types and the round-robin pick function for the 4-way mux arbiter.
// Imported by the arbiter top and the 4:1 datapath.
package mux4_arb_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } rr_pick_t;

    // Scans req cyclically from start, skipping bits set in excl; the first set bit wins.
    function automatic rr_pick_t rr_pick(
        input logic [NUM_REQ-1:0] req,
        input logic [1:0]         start,
        input logic [NUM_REQ-1:0] excl
    );
        rr_pick_t           r;
        logic [NUM_REQ-1:0] m;
        logic [1:0]         k;
        r.found = 1'b0;
        r.idx   = 2'b00;
        m       = req & ~excl;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = start + i[1:0];
            if (!r.found && m[k]) begin
                r.found = 1'b1;
                r.idx   = k;
            end
        end
        return r;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot4(input logic [1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = 4'b0000;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux_4x1.sv
// WIDTH-wide 4:1 datapath; output forced to zero when not enabled.
module mux_4x1
    import mux4_arb_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [4*WIDTH-1:0] in,
    input  logic [1:0]         sel,
    input  logic               en,
    output logic [WIDTH-1:0]   y
);

    logic [WIDTH-1:0] lane_s;

    // Lane select followed by valid gating.
    always_comb begin
        lane_s = '0;
        case (sel)
            2'd0:    lane_s = in[0*WIDTH +: WIDTH];
            2'd1:    lane_s = in[1*WIDTH +: WIDTH];
            2'd2:    lane_s = in[2*WIDTH +: WIDTH];
            2'd3:    lane_s = in[3*WIDTH +: WIDTH];
            default: lane_s = '0;
        endcase
        if (en) begin
            y = lane_s;
        end else begin
            y = '0;
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning the select of a shared 4:1 channel, with a hold
// counter that forces a handoff once a contended grant has lasted MAX_HOLD cycles.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int WIDTH    = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           req,
    input  logic [4*WIDTH-1:0]   in,
    output logic [3:0]           gnt,
    output logic [1:0]           sel,
    output logic [WIDTH-1:0]     y,
    output logic                 y_valid
);

    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t            state_r, state_s;
    logic [3:0]        gnt_r, gnt_s;
    logic [1:0]        sel_r, sel_s;
    logic              y_valid_r, y_valid_s;
    logic [1:0]        ptr_r, ptr_s;
    logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_s;

    rr_pick_t          pick_s;
    logic              release_s;
    logic              timeout_s;
    logic              others_s;

    // Next-state logic: idle arbitration, release/timeout handoff, hold counting.
    always_comb begin
        state_s    = state_r;
        gnt_s      = gnt_r;
        sel_s      = sel_r;
        y_valid_s  = y_valid_r;
        ptr_s      = ptr_r;
        hold_cnt_s = hold_cnt_r;
        pick_s     = '0;
        release_s  = 1'b0;
        timeout_s  = 1'b0;
        others_s   = 1'b0;
        case (state_r)
            IDLE: begin
                pick_s = rr_pick(req, ptr_r, 4'b0000);
                if (pick_s.found) begin
                    gnt_s      = onehot4(pick_s.idx);
                    sel_s      = pick_s.idx;
                    y_valid_s  = 1'b1;
                    hold_cnt_s = '0;
                    state_s    = BUSY;
                end else begin
                    state_s    = IDLE;
                end
            end
            BUSY: begin
                release_s = ~req[sel_r];
                others_s  = |(req & ~onehot4(sel_r));
                timeout_s = (hold_cnt_r == HOLD_LAST) && others_s;
                if (release_s || timeout_s) begin
                    pick_s = rr_pick(req, sel_r + 2'd1, onehot4(sel_r));
                    ptr_s  = sel_r + 2'd1;
                    if (pick_s.found) begin
                        gnt_s      = onehot4(pick_s.idx);
                        sel_s      = pick_s.idx;
                        hold_cnt_s = '0;
                        state_s    = BUSY;
                    end else begin
                        gnt_s      = 4'b0000;
                        y_valid_s  = 1'b0;
                        state_s    = IDLE;
                    end
                end else if (hold_cnt_r != HOLD_LAST) begin
                    hold_cnt_s = hold_cnt_r + {{(HOLD_W-1){1'b0}}, 1'b1};
                end else begin
                    hold_cnt_s = hold_cnt_r;
                end
            end
            default: begin
                state_s   = IDLE;
                gnt_s     = 4'b0000;
                y_valid_s = 1'b0;
            end
        endcase
    end

    // State registers; reset wins over every transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            gnt_r      <= 4'b0000;
            sel_r      <= 2'd0;
            y_valid_r  <= 1'b0;
            ptr_r      <= 2'd0;
            hold_cnt_r <= '0;
        end else begin
            state_r    <= state_s;
            gnt_r      <= gnt_s;
            sel_r      <= sel_s;
            y_valid_r  <= y_valid_s;
            ptr_r      <= ptr_s;
            hold_cnt_r <= hold_cnt_s;
        end
    end

    assign gnt     = gnt_r;
    assign sel     = sel_r;
    assign y_valid = y_valid_r;

    mux_4x1 #(
        .WIDTH (WIDTH)
    ) u_mux (
        .in  (in),
        .sel (sel_r),
        .en  (y_valid_r),
        .y   (y)
    );

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter (WIDTH=1, MAX_HOLD=8) with hand-computed expectations.
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] in;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic [0:0] y;
    logic       y_valid;

    int checks   = 0;
    int failures = 0;

    mux4_rr_arbiter #(
        .WIDTH    (1),
        .MAX_HOLD (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .in      (in),
        .gnt     (gnt),
        .sel     (sel),
        .y       (y),
        .y_valid (y_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] exp_gnt;
        rst = 1'b1;
        req = 4'b1111;
        in  = 4'b0000;

        // Reset held with all requests up
        tick();
        tick();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_sel", 32'(sel), 32'h0);
        check("rst_yv", 32'(y_valid), 32'h0);
        check("rst_y", 32'(y), 32'h0);
        check("rst_ptr", 32'(dut.ptr_r), 32'h0);
        check("rst_hold", 32'(dut.hold_cnt_r), 32'h0);
        rst = 1'b0;
        tick();
        check("first_gnt", 32'(gnt), 32'h1);
        check("first_yv", 32'(y_valid), 32'h1);
        in = 4'b0001;
        #1;
        check("first_y", 32'(y), 32'h1);

        // Single requester on lane 2
        rst = 1'b1; req = 4'b0000;
        tick();
        rst = 1'b0;
        tick();
        check("idle_gnt", 32'(gnt), 32'h0);
        req = 4'b0100; in = 4'b0100;
        tick();
        check("single_sel", 32'(sel), 32'h2);
        check("single_y", 32'(y), 32'h1);
        for (int c = 0; c < 20; c++) begin
            check("single_hold_gnt", 32'(gnt), 32'h4);
            tick();
        end
        req = 4'b0000;
        tick();
        check("single_rel_gnt", 32'(gnt), 32'h0);
        check("single_rel_yv", 32'(y_valid), 32'h0);
        check("single_rel_y", 32'(y), 32'h0);
        check("single_rel_ptr", 32'(dut.ptr_r), 32'h3);

        // Round-robin fairness, all four contending
        rst = 1'b1;
        tick();
        rst = 1'b0; req = 4'b1111;
        tick();
        for (int g = 0; g < 5; g++) begin
            exp_gnt = 4'b0001 << (g % 4);
            for (int c = 0; c < 8; c++) begin
                check("rr_gnt", 32'(gnt), 32'(exp_gnt));
                check("rr_yv", 32'(y_valid), 32'h1);
                tick();
            end
        end

        // Direct handoff on release, then pointer wrap from 3 to 0
        rst = 1'b1; req = 4'b0000;
        tick();
        rst = 1'b0; req = 4'b1010;
        tick();
        check("ho_gnt1", 32'(gnt), 32'h2);
        req = 4'b1000; in = 4'b1000;
        tick();
        check("ho_gnt3", 32'(gnt), 32'h8);
        check("ho_yv", 32'(y_valid), 32'h1);
        check("ho_sel", 32'(sel), 32'h3);
        check("ho_y", 32'(y), 32'h1);
        check("ho_ptr", 32'(dut.ptr_r), 32'h2);
        req = 4'b0000;
        tick();
        check("wrap_idle_gnt", 32'(gnt), 32'h0);
        check("wrap_ptr", 32'(dut.ptr_r), 32'h0);
        req = 4'b1001;
        tick();
        check("wrap_gnt", 32'(gnt), 32'h1);

        // Reset mid-grant, then full-length timeout after regrant
        rst = 1'b1; req = 4'b0000;
        tick();
        rst = 1'b0; req = 4'b0100;
        tick();
        for (int c = 0; c < 5; c++) tick();
        check("mid_hold", 32'(dut.hold_cnt_r), 32'h5);
        check("mid_gnt", 32'(gnt), 32'h4);
        rst = 1'b1;
        tick();
        check("mid_rst_gnt", 32'(gnt), 32'h0);
        check("mid_rst_sel", 32'(sel), 32'h0);
        check("mid_rst_yv", 32'(y_valid), 32'h0);
        check("mid_rst_y", 32'(y), 32'h0);
        check("mid_rst_hold", 32'(dut.hold_cnt_r), 32'h0);
        rst = 1'b0;
        tick();
        check("regrant_hold", 32'(dut.hold_cnt_r), 32'h0);
        req = 4'b0110;
        for (int c = 0; c < 8; c++) begin
            check("to_keep_gnt", 32'(gnt), 32'h4);
            tick();
        end
        check("to_handoff_gnt", 32'(gnt), 32'h2);
        check("to_handoff_yv", 32'(y_valid), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter that shares one 4:1 multiplexed output channel among four requesters. It registers a one-hot grant and the matching 2-bit select, and routes the granted requester's data to the shared output. A hold counter bounds how long one requester can keep the channel while others wait. It sits directly in front of the 4:1 mux datapath and is its only source of select.

## Interface
- WIDTH, 1, data width per requester and of the shared output
- MAX_HOLD, 8, maximum consecutive grant cycles while another request is pending; legal range ≥ 1
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- req  input  4  request per requester; level-sensitive, held high while the channel is wanted
- in  input  4*WIDTH  requester data; requester k occupies in[k*WIDTH +: WIDTH]
- gnt  output  4  registered one-hot grant, all zero when idle
- sel  output  2  registered index of the granted requester, drives the mux select
- y  output  WIDTH  in[sel] when y_valid is 1, otherwise 0
- y_valid  output  1  registered; 1 whenever gnt ≠ 0

## Operation
- Reset values: gnt=0, sel=0, y_valid=0, y=0, state=IDLE, priority pointer ptr=0, hold_cnt=0.
- Arbitration function: scan req cyclically from a start index, starting at ptr in IDLE and at sel+1 mod 4 in BUSY. The first set bit wins.
- IDLE:
  - If req≠0, the winner is loaded into gnt/sel, y_valid=1, hold_cnt=0, next state BUSY.
  - Otherwise stay in IDLE.
- BUSY, evaluated every cycle using the current req:
  - Release: req[sel]=0.
  - Timeout: hold_cnt = MAX_HOLD-1 and req has any bit other than sel set.
  - On release or timeout, arbitrate from sel+1, excluding sel.
    - If a winner exists, hand off directly to it: load gnt/sel, hold_cnt=0, stay BUSY. There is no idle bubble.
    - If there is no winner (release only), clear gnt and y_valid, set ptr=sel+1 mod 4, go to IDLE.
  - Otherwise keep the grant and increment hold_cnt, saturating at MAX_HOLD-1.
  - If req[sel]=1 and no other request is pending, the grant is held indefinitely.
- On every handoff or release, ptr is updated to (old sel)+1 mod 4.
- y is combinational from the registered sel and the live in; it is forced to 0 when y_valid=0.
- hold_cnt width is $clog2(MAX_HOLD) with a minimum of 1.
- MAX_HOLD=1 means a contended grant lasts exactly 1 cycle, which is strict rotation.

## Timing
- Grant latency: req rising in cycle N (sampled at edge N+1) produces gnt/sel/y_valid valid after edge N+1. That is 1 cycle.
- Data path: y follows in combinationally within the same cycle once the grant is registered.
- Handoff: the old grant deasserts and the new grant asserts on the same edge. gnt is never two-hot and is never zero between back-to-back grants.
- Release with no other requests: gnt=0 one cycle after req[sel] drops.
- A requester that drops req and re-raises it while waiting loses nothing. Arbitration is purely level-based each cycle.
- Reset mid-grant: the next edge with rst=1 forces all reset values regardless of req. rst has priority over every transition.
- Simultaneous release and new requests: the handoff rule applies, and the new requests are served on the same edge.

## Structure
- Shared package mux4_arb_pkg holds:
  - state enum {IDLE, BUSY}
  - constant NUM_REQ=4
  - a function returning the round-robin winner index plus a found flag, given req, start index and exclude mask
- One sub-module, mux_4x1, implements the WIDTH-wide 4:1 datapath, selected by sel and gated by y_valid. The arbiter FSM, pointer and hold counter live in mux4_rr_arbiter.

## Test plan
- Reset/idle: hold rst=1 for 2 cycles with req=4'b1111.
  - Expect gnt=0, sel=0, y_valid=0, y=0.
  - After releasing rst, expect gnt=4'b0001 one cycle later.
- Single requester: req=4'b0100 with in lane 2 = 1 (WIDTH=1).
  - One cycle later expect gnt=4'b0100, sel=2, y=1, held for 20 cycles.
  - Dropping req gives gnt=0 on the next edge, with ptr=3.
- Round-robin fairness: MAX_HOLD=8, req=4'b1111 held.
  - Expect grants in order 0,1,2,3,0.
  - Each grant lasts exactly 8 cycles.
  - No zero-gnt gaps; gnt is one-hot every cycle.
- Direct handoff on release: grant on requester 1 with req=4'b1010.
  - Drop req[1]. Expect gnt goes from 4'b0010 to 4'b1000 on one edge and y_valid stays 1.
- Pointer wrap: after a grant to requester 3 releases to idle, assert req=4'b1001.
  - Expect requester 0 granted, not 3.
- Reset mid-grant: assert rst while gnt=4'b0100 and hold_cnt=5.
  - Next edge expect all outputs 0.
  - With req=4'b0100 still high after rst falls, expect a regrant with hold_cnt restarting from 0, so the timeout comes a full MAX_HOLD cycles later.
